// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer for an external 4:1 mux: grants one requester, registers the
// mux output and hands it downstream over valid/ready. Define ARB_BURST_EN for burst re-grants.
module mux4_rr_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    output logic [1:0]            sel,
    input  logic [DATA_WIDTH-1:0] mux_o,
    output logic [3:0]            ack,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {
        StIdle,
        StSelect,
        StValid
    } state_e;

    if (BURST_LEN < 2 || BURST_LEN > 16) begin : g_burst_len_check
        $error("BURST_LEN must be in 2..16");
    end

    state_e                  state_q, state_d;
    logic [1:0]              sel_q, sel_d;
    logic [3:0]              gnt_q, gnt_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic [1:0]              last_q, last_d;
    logic [1:0]              rr_winner;
    logic                    handshake;

    // First requester found scanning from the one after the last winner.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        rr_winner = last_q;
        found     = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (req[idx] && !found) begin
                rr_winner = idx;
                found     = 1'b1;
            end
        end
    end

    assign handshake = out_valid_q & out_ready;

`ifdef ARB_BURST_EN
    logic [3:0] beat_cnt_q, beat_cnt_d;
    logic       burst_regrant;

    assign burst_regrant = req[last_q] && (beat_cnt_q < 4'(BURST_LEN - 1));

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (state_q == StIdle) begin
            if (!req[last_q]) begin
                beat_cnt_d = '0;
            end else if (|req) begin
                beat_cnt_d = burst_regrant ? beat_cnt_q + 4'd1 : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    logic burst_regrant;

    assign burst_regrant = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StSelect;
                end
            end
            StSelect: state_d = StValid;
            StValid: begin
                if (handshake) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: grant, capture, release.
    always_comb begin
        logic [1:0] winner;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        winner      = burst_regrant ? last_q : rr_winner;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    sel_d = winner;
                    gnt_d = 4'b0001 << winner;
                end
            end
            StSelect: begin
                out_data_d  = mux_o;
                out_valid_d = 1'b1;
            end
            StValid: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    last_d      = sel_q;
                    gnt_d       = '0;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                gnt_d       = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= '0;
            gnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            last_q      <= 2'd3;
        end else begin
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    // Outputs.
    always_comb begin
        ack       = gnt_q & {4{handshake}};
        busy      = (state_q != StIdle);
        sel       = sel_q;
        out_data  = out_data_q;
        out_valid = out_valid_q;
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, single request, contention, backpressure,
// rotation/burst pattern and asynchronous reset during a transfer.
module tb_mux4_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [1:0]  sel;
    logic [31:0] mux_o;
    logic [3:0]  ack;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [31:0] a, b, c, d;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            2'd0:    mux_o = a;
            2'd1:    mux_o = b;
            2'd2:    mux_o = c;
            default: mux_o = d;
        endcase
    end

    mux4_rr_arbiter #(
        .DATA_WIDTH(32),
        .BURST_LEN (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .sel      (sel),
        .mux_o    (mux_o),
        .ack      (ack),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] data_tbl [4];
        int          w;

        rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0;
        a = '0; b = '0; c = '0; d = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);

        // Single request from c.
        c = 32'hCAFEF00D; req = 4'b0100; out_ready = 1'b1;
        @(negedge clk);
        chk("single_sel", 32'(sel), 32'd2);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_valid_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", out_data, 32'hCAFEF00D);
        chk("single_ack", 32'(ack), 32'b0100);
        req = 4'b0000;
        @(negedge clk);
        chk("single_ack_drop", 32'(ack), 32'd0);
        chk("single_valid_drop", 32'(out_valid), 32'd0);
        chk("single_busy_drop", 32'(busy), 32'd0);
        chk("single_sel_hold", 32'(sel), 32'd2);

        // Full contention: strict rotation a,b,c,d,a, three cycles per beat.
        reset_pulse();
        a = 32'hFFFFFFFF; b = 32'hAAAAAAAA; c = 32'h00000000; d = 32'h11111111;
        data_tbl[0] = a; data_tbl[1] = b; data_tbl[2] = c; data_tbl[3] = d;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("cont%0d_sel", k), 32'(sel), 32'(k % 4));
            chk($sformatf("cont%0d_pre", k), 32'(out_valid), 32'd0);
            @(negedge clk);
            chk($sformatf("cont%0d_data", k), out_data, data_tbl[k % 4]);
            chk($sformatf("cont%0d_ack", k), 32'(ack), 32'(4'b0001 << (k % 4)));
            if (k == 4) req = 4'b0000;
            @(negedge clk);
            chk($sformatf("cont%0d_post", k), 32'(out_valid), 32'd0);
        end

        // Backpressure on requester 0.
        a = 32'h12345678; req = 4'b0001; out_ready = 1'b0;
        @(negedge clk);
        chk("bp_sel", 32'(sel), 32'd0);
        @(negedge clk);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_data", out_data, 32'h12345678);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_data", k), out_data, 32'h12345678);
            chk($sformatf("bp_hold%0d_ack", k), 32'(ack), 32'd0);
        end
        out_ready = 1'b1; req = 4'b0000;
        #1;
        chk("bp_ack", 32'(ack), 32'b0001);
        @(negedge clk);
        chk("bp_valid_drop", 32'(out_valid), 32'd0);
        chk("bp_ack_drop", 32'(ack), 32'd0);

        // Two requesters held: alternate, or bursts of four with ARB_BURST_EN.
        reset_pulse();
        a = 32'hAAAA0000; b = 32'hBBBB1111; req = 4'b0011; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
`ifdef ARB_BURST_EN
            w = (k / 4) % 2;
`else
            w = k % 2;
`endif
            repeat (2) @(negedge clk);
            chk($sformatf("pair%0d_data", k), out_data, (w == 0) ? 32'hAAAA0000 : 32'hBBBB1111);
            chk($sformatf("pair%0d_ack", k), 32'(ack), 32'(4'b0001 << w));
            if (k == 7) req = 4'b0000;
            @(negedge clk);
        end

        // Asynchronous reset while holding a valid beat.
        b = 32'h5A5A5A5A; req = 4'b0010; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_valid", 32'(out_valid), 32'd1);
        chk("mid_sel", 32'(sel), 32'd1);
        rst_n = 1'b0; out_ready = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_sel", 32'(sel), 32'd0);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; req = 4'b0000;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4:1 32-bit mux datapath (inputs a/b/c/d, select sel, output o).
- Four requesters present data on mux inputs a..d; block picks one, drives the mux select, registers mux output, delivers it downstream over a valid/ready handshake.
- Sits between the four data sources and a single downstream consumer; mux itself stays external and combinational.

Parameters:
- DATA_WIDTH, 32, width of mux data path and out_data.
- BURST_LEN, 4, max consecutive beats per grant when ARB_BURST_EN defined (legal 2..16); ignored otherwise.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  req[i]=1: requester i has valid data on mux input i (0=a,1=b,2=c,3=d).
- sel  output  2  select to mux sel.
- mux_o  input  DATA_WIDTH  mux output o.
- ack  output  4  one-hot, combinational: gnt & {4{out_valid & out_ready}}.
- out_data  output  DATA_WIDTH  registered beat to consumer.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts when high with out_valid.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sel=0, gnt=0, out_data=0, out_valid=0, ack=0, busy=0, last=3 (requester 0 has top priority after reset), beat_cnt=0. Takes effect immediately, including mid-transfer; in-flight beat discarded, no ack.
- States: IDLE, SELECT, VALID.
- IDLE: if req==0 stay. Else winner = first i with req[i]=1 scanning last+1, last+2, last+3, last+4 (mod 4); sel<=winner, gnt<=onehot(winner), ->SELECT.
- SELECT: one cycle for mux settling; out_data<=mux_o, out_valid<=1, ->VALID.
- VALID: hold out_data/out_valid while out_ready=0 (no timeout). On out_valid&out_ready: ack[winner] high that cycle; at edge out_valid<=0, last<=sel, gnt<=0, ->IDLE.
- Latency: req rising sampled at edge N -> sel valid after N; out_valid after edge N+1. Minimum 3 cycles per beat.
- Requester protocol: hold req and data stable from assertion until ack; at ack edge either present next data (keep req) or drop req. Dropping req while granted is a protocol violation; arbiter still completes the beat with captured data.
- sel holds its last value in IDLE (not returned to 0).
- Single active requester re-granted each beat (rotation wraps to itself).
- Simultaneous req from all four: strict rotation 0,1,2,3,0...

Optional Feature:
- ARB_BURST_EN defined: in IDLE, if req[last]=1 and beat_cnt < BURST_LEN-1, re-grant last without rotation, beat_cnt++; otherwise normal rotation and beat_cnt<=0. beat_cnt also cleared when requester drops req. Gives up to BURST_LEN consecutive beats per requester.
- Not defined: no beat_cnt logic; every beat re-arbitrates by rotation.

Test Plan:
- Reset: hold rst_n=0 -> sel=0, out_valid=0, out_data=0, ack=0, busy=0; release with req=0 -> stays IDLE.
- Single request: c=0xCAFEF00D, req=4'b0100, out_ready=1 -> sel=2 after 1st edge, out_valid=1 with out_data=0xCAFEF00D after 2nd edge, ack=4'b0100 for exactly one cycle.
- Full contention: a=0xFFFFFFFF, b=0xAAAAAAAA, c=0x0, d=0x11111111, req=4'b1111, out_ready=1, macro off -> out_data sequence FFFFFFFF, AAAAAAAA, 00000000, 11111111, FFFFFFFF; one beat per 3 cycles.
- Backpressure: req=4'b0001, out_ready=0 for 5 cycles after out_valid -> out_data/out_valid stable, ack=0; raise out_ready -> ack[0] pulse, out_valid drops next edge.
- Burst (ARB_BURST_EN, BURST_LEN=4): req=4'b0011 held -> 4 beats from a then 4 from b, repeating; same stimulus with macro off -> a,b alternate.
- Reset mid-operation: assert rst_n=0 while in VALID -> out_valid, busy, sel clear immediately without clock edge; no ack generated.
